// File: rtl/msrv32_rst_pkg.sv
// Shared types and defaults for the msrv32 reset sequencer / real-time counter controller.
package msrv32_rst_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } rst_state_e;

  localparam int RC_WIDTH_DEF    = 64;
  localparam int HOLD_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int RC_PRESCALE_DEF = 1;

  // Hold counter needs to reach HOLD_CYCLES-1 with one bit of headroom.
  function automatic int hold_cnt_width(input int hold_cycles);
    return $clog2(hold_cycles) + 1;
  endfunction

  // Prescaler counts 0..RC_PRESCALE-1; keep at least one bit when no prescaling.
  function automatic int prescale_width(input int rc_prescale);
    return (rc_prescale > 1) ? $clog2(rc_prescale) : 1;
  endfunction

endpackage

// File: rtl/msrv32_rst_rc_ctrl_if.sv
// Soft-reset handshake and real-time-counter bus between the controller and the core side.
interface msrv32_rst_rc_ctrl_if #(
  parameter int RC_WIDTH = 64
) ();

  logic                soft_rst_req_in;
  logic                soft_rst_ack_out;
  logic                rc_en_in;
  logic                rc_load_in;
  logic [RC_WIDTH-1:0] rc_load_val_in;
  logic                core_rst_out;
  logic                rst_done_out;
  logic [RC_WIDTH-1:0] ms_riscv32_mp_rc_out;
  logic                rc_tick_out;

  // Controller side.
  modport slave (
    input  soft_rst_req_in, rc_en_in, rc_load_in, rc_load_val_in,
    output soft_rst_ack_out, core_rst_out, rst_done_out, ms_riscv32_mp_rc_out, rc_tick_out
  );

  // Requester / core side.
  modport master (
    output soft_rst_req_in, rc_en_in, rc_load_in, rc_load_val_in,
    input  soft_rst_ack_out, core_rst_out, rst_done_out, ms_riscv32_mp_rc_out, rc_tick_out
  );

endinterface

// File: rtl/msrv32_rst_sync.sv
// Async-assert / sync-release reset synchronizer; sync_ok rises SYNC_STAGES edges after release.
module msrv32_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  // Shift a constant one into the chain each edge.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Chain clears immediately on reset and fills one stage per edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_ok = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/msrv32_rst_rc_ctrl.sv
// Reset sequencer (sync release, stretched core reset, soft-reset handshake) and
// prescaled real-time counter feeding the msrv32 core.
module msrv32_rst_rc_ctrl
  import msrv32_rst_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int RC_PRESCALE = RC_PRESCALE_DEF,
  parameter int RC_WIDTH    = RC_WIDTH_DEF
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  msrv32_rst_rc_ctrl_if.slave   bus
);

  localparam int CNT_W = hold_cnt_width(HOLD_CYCLES);
  localparam int PS_W  = prescale_width(RC_PRESCALE);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(RC_PRESCALE - 1);

  logic                sync_ok_s;
  logic                accept_s;

  rst_state_e          state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                armed_q,    armed_d;
  logic                ack_q,      ack_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q,     done_d;
  logic [PS_W-1:0]     ps_q,       ps_d;
  logic [RC_WIDTH-1:0] rc_q,       rc_d;
  logic                tick_q,     tick_d;

  msrv32_rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (ms_riscv32_mp_clk_in),
    .rst     (ms_riscv32_mp_rst_in),
    .sync_ok (sync_ok_s)
  );

  // Reset FSM next state, hold counter, soft-request arming and registered reset outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (sync_ok_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.soft_rst_req_in && armed_q) begin
          state_d  = ST_HOLD;
          cnt_d    = '0;
          accept_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase

    // A request must be seen low after each ack (or reset) before it can fire again.
    if (accept_s) begin
      armed_d = 1'b0;
    end else if (!bus.soft_rst_req_in) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    ack_d      = accept_s;
    core_rst_d = (state_d != ST_RUN);
    done_d     = (state_d == ST_RUN);
  end

  // Real-time counter: load beats increment; prescaler gates increments; wraps silently.
  always_comb begin
    rc_d   = rc_q;
    ps_d   = ps_q;
    tick_d = 1'b0;
    if (sync_ok_s) begin
      if (bus.rc_load_in) begin
        rc_d = bus.rc_load_val_in;
        ps_d = '0;
      end else if (bus.rc_en_in) begin
        if (ps_q == PS_LAST) begin
          ps_d   = '0;
          rc_d   = rc_q + RC_WIDTH'(1);
          tick_d = 1'b1;
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end else begin
        rc_d = rc_q;
        ps_d = ps_q;
      end
    end else begin
      rc_d = rc_q;
      ps_d = ps_q;
    end
  end

  // State and output registers; raw reset forces every value back immediately.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= ST_SYNC;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      ack_q      <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      ps_q       <= '0;
      rc_q       <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      ack_q      <= ack_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      ps_q       <= ps_d;
      rc_q       <= rc_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.soft_rst_ack_out     = ack_q;
  assign bus.core_rst_out         = core_rst_q;
  assign bus.rst_done_out         = done_q;
  assign bus.ms_riscv32_mp_rc_out = rc_q;
  assign bus.rc_tick_out          = tick_q;

endmodule

// File: tb/tb_msrv32_rst_rc_ctrl.sv
// Bench for msrv32_rst_rc_ctrl: two instances (prescale 1 and 4) share clock, reset and
// stimulus; a reference model built from edge counts and enabled-cycle totals predicts
// every output after every edge.
module tb_msrv32_rst_rc_ctrl;

  localparam int SYNC = 2;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  msrv32_rst_rc_ctrl_if #(.RC_WIDTH(64)) ifa ();
  msrv32_rst_rc_ctrl_if #(.RC_WIDTH(64)) ifb ();

  msrv32_rst_rc_ctrl #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .RC_PRESCALE(1), .RC_WIDTH(64))
    dut_a (.ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(ifa));
  msrv32_rst_rc_ctrl #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .RC_PRESCALE(4), .RC_WIDTH(64))
    dut_b (.ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;

  // Driven inputs (copied to both interfaces).
  bit          d_req, d_en, d_load;
  logic [63:0] d_val;

  // Reference model state.
  int              m_edges;
  int              m_run_at;
  bit              m_armed;
  logic [63:0]     m_base [2];
  longint unsigned m_nen  [2];
  longint unsigned m_ps   [2] = '{64'd1, 64'd4};
  logic [63:0]     e_rc   [2];
  bit              e_tick [2];
  bit              e_ack, e_core_rst, e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit req, input bit en, input bit load, input logic [63:0] val);
    d_req = req; d_en = en; d_load = load; d_val = val;
    ifa.soft_rst_req_in = req; ifa.rc_en_in = en; ifa.rc_load_in = load; ifa.rc_load_val_in = val;
    ifb.soft_rst_req_in = req; ifb.rc_en_in = en; ifb.rc_load_in = load; ifb.rc_load_val_in = val;
  endtask

  task automatic model_reset();
    m_edges  = 0;
    m_run_at = SYNC + HOLD + 1;
    m_armed  = 1'b0;
    e_ack = 1'b0; e_core_rst = 1'b1; e_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_base[i] = 64'd0; m_nen[i] = 64'd0; e_rc[i] = 64'd0; e_tick[i] = 1'b0;
    end
  endtask

  // Expected outputs after edge k, derived from edge counts since release.
  task automatic model_edge();
    int k;
    bit active, accept;
    k      = m_edges + 1;
    active = (k - 1) >= SYNC;
    accept = ((k - 1) >= m_run_at) && d_req && m_armed;
    if (accept) m_run_at = k + HOLD;
    if (accept) m_armed = 1'b0;
    else if (!d_req) m_armed = 1'b1;
    e_ack      = accept;
    e_core_rst = (k < m_run_at);
    e_done     = !e_core_rst;
    for (int i = 0; i < 2; i++) begin
      e_tick[i] = 1'b0;
      if (active) begin
        if (d_load) begin
          m_base[i] = d_val;
          m_nen[i]  = 64'd0;
        end else if (d_en) begin
          m_nen[i]++;
          if ((m_nen[i] % m_ps[i]) == 64'd0) e_tick[i] = 1'b1;
        end
        e_rc[i] = m_base[i] + (m_nen[i] / m_ps[i]);
      end
    end
    m_edges = k;
  endtask

  task automatic check_all();
    chk("core_rst_a", ifa.core_rst_out, e_core_rst);
    chk("core_rst_b", ifb.core_rst_out, e_core_rst);
    chk("done_a", ifa.rst_done_out, e_done);
    chk("done_b", ifb.rst_done_out, e_done);
    chk("ack_a", ifa.soft_rst_ack_out, e_ack);
    chk("ack_b", ifb.soft_rst_ack_out, e_ack);
    chk("rc_a", ifa.ms_riscv32_mp_rc_out, e_rc[0]);
    chk("rc_b", ifb.ms_riscv32_mp_rc_out, e_rc[1]);
    chk("tick_a", ifa.rc_tick_out, e_tick[0]);
    chk("tick_b", ifb.rc_tick_out, e_tick[1]);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_rst_a"}, ifa.core_rst_out, 64'd1);
    chk({tag, "_core_rst_b"}, ifb.core_rst_out, 64'd1);
    chk({tag, "_done_a"}, ifa.rst_done_out, 64'd0);
    chk({tag, "_ack_a"}, ifa.soft_rst_ack_out, 64'd0);
    chk({tag, "_tick_a"}, ifa.rc_tick_out, 64'd0);
    chk({tag, "_rc_a"}, ifa.ms_riscv32_mp_rc_out, 64'd0);
    chk({tag, "_rc_b"}, ifb.ms_riscv32_mp_rc_out, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int acks;
  int n_edge;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    model_reset();
    #2 rst = 1'b1;
    #10;
    check_reset_values("por");

    // Release just after an edge; following edges are numbered from 1.
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Release timing plus prescaled counting with enable gaps.
    for (int k = 1; k <= 28; k++) begin
      drive(1'b0, (k <= 14) || (k >= 20 && k <= 21) || (k >= 27), 1'b0, 64'd0);
      step();
      if (k == 14) begin
        chk("rc_b_12_en", ifb.ms_riscv32_mp_rc_out, 64'd3);
        chk("tick_b_12_en", ifb.rc_tick_out, 64'd1);
      end
      if (k == 18) chk("core_rst_edge18", ifa.core_rst_out, 64'd1);
      if (k == 19) begin
        chk("core_rst_edge19", ifa.core_rst_out, 64'd0);
        chk("done_edge19", ifa.rst_done_out, 64'd1);
        chk("rc_b_frozen", ifb.ms_riscv32_mp_rc_out, 64'd3);
      end
      if (k == 21) chk("tick_b_partial", ifb.rc_tick_out, 64'd0);
      if (k == 28) begin
        chk("rc_b_resume", ifb.ms_riscv32_mp_rc_out, 64'd4);
        chk("tick_b_resume", ifb.rc_tick_out, 64'd1);
      end
    end

    // One-cycle soft request in RUN; counter keeps running.
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    step();
    chk("soft_ack_n", ifa.soft_rst_ack_out, 64'd1);
    chk("soft_rst_n", ifa.core_rst_out, 64'd1);
    drive(1'b0, 1'b1, 1'b0, 64'd0);
    step();
    chk("soft_ack_n1", ifa.soft_rst_ack_out, 64'd0);
    for (int k = 2; k <= 15; k++) step();
    chk("soft_rst_n15", ifa.core_rst_out, 64'd1);
    step();
    chk("soft_rst_n16", ifa.core_rst_out, 64'd0);
    for (int k = 0; k < 4; k++) step();

    // Level held high for 40 cycles: exactly one ack; re-arm needs a low sample.
    acks = 0;
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    for (int k = 0; k < 40; k++) begin
      step();
      if (ifa.soft_rst_ack_out === 1'b1) acks++;
    end
    chk("held_req_acks", 64'(acks), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    step();
    chk("rearm_ack", ifa.soft_rst_ack_out, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    for (int k = 0; k < 20; k++) step();

    // Load beats enable; then wrap through all-ones.
    drive(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    chk("load_wins", ifa.ms_riscv32_mp_rc_out, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("load_no_tick", ifa.rc_tick_out, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 64'd0);
    step();
    chk("inc_to_ff", ifa.ms_riscv32_mp_rc_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("wrap_to_0", ifa.ms_riscv32_mp_rc_out, 64'd0);
    chk("wrap_tick", ifa.rc_tick_out, 64'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(7) == 0) ? ~d_req : d_req,
            $urandom_range(3) != 0,
            $urandom_range(31) == 0,
            ($urandom_range(1) == 0) ? {32'hFFFF_FFFF, $urandom} : {$urandom, $urandom});
      step();
    end

    // Enter HOLD via soft reset, then assert raw reset between edges.
    drive(1'b0, 1'b1, 1'b0, 64'd0);
    for (int k = 0; k < 20; k++) step();
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    step();
    chk("pre_async_ack", ifa.soft_rst_ack_out, 64'd1);
    drive(1'b0, 1'b1, 1'b0, 64'd0);
    for (int k = 0; k < 3; k++) step();
    #2 rst = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_edge = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      n_edge++;
    end
    chk("recover_edges", 64'(n_edge), 64'd25);
    chk("recover_done", ifa.rst_done_out, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
